// File: rtl/serial_add_unit_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and slice width.
package serial_add_unit_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add_slice_4b.sv
// 4-bit ripple slice; also exposes the carry into bit 3 so the top can derive signed overflow.
module add_slice_4b
  import serial_add_unit_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out,
  output logic                c3
);

  logic [3:0] lo;
  logic [1:0] hi;

  // Split at bit 3 so the carry into the sign position of the slice is visible.
  assign lo    = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, c_in};
  assign hi    = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo[3]};
  assign sum   = {hi[0], lo[2:0]};
  assign c_out = hi[1];
  assign c3    = lo[3];

endmodule

// File: rtl/serial_add_unit.sv
// Nibble-serial add/subtract unit: one 4-bit slice per cycle, LSB nibble first.
// Optional zero-result flag output enabled by defining SERIAL_ADD_ZERO_FLAG_EN.
module serial_add_unit
  import serial_add_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NUM_NIB = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NUM_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                s_co, s_c3;

  always_comb begin
    a_nib = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    b_nib = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  end

  add_slice_4b u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry_q),
    .sum   (s_nib),
    .c_out (s_co),
    .c3    (s_c3)
  );

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    co_d     = co_q;
    ov_d     = ov_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
          a_d     = operand_a;
          b_d     = sub ? ~operand_b : operand_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = s_nib;
        carry_d = s_co;
        if (idx_q == LAST_IDX) begin
          co_d    = s_co;
          ov_d    = s_co ^ s_c3;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
          zero_d  = (result_d == '0);
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      ov_q     <= ov_d;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit: driver pushes expected results, monitor pops on handshake.
module tb_serial_add_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  serial_add_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every result handshake must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(result), 64'(e.r));
          check("carry_out", 64'(carry_out), 64'(e.co));
          check("overflow", 64'(overflow), 64'(e.ov));
`ifdef SERIAL_ADD_ZERO_FLAG_EN
          check("zero", 64'(zero), 64'(e.z));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one op; returns after the accept edge with operands scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_valid  = 1'b1;
    operand_a = a;
    operand_b = b;
    sub       = s;
    tick();
    in_valid  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    sub       = 1'($urandom_range(0, 1));
  endtask

  // Counts edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] r, input logic co, input logic ov, input logic z);
    int edges;
    sb_q.push_back('{r: r, co: co, ov: ov, z: z});
    issue(a, b, s);
    wait_done(edges);
    check("latency_edges", 64'(edges), 64'(W / 4 + 1));
    check("in_ready_in_done", 64'(in_ready), 64'd0);
    tick();
    check("in_ready_after_done", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int edges;
    exp_t held;

    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_flags", 64'({carry_out, overflow}), 64'd0);

    do_op(32'h0000_0001, 32'h0000_000F, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

    // Abort mid-RUN: nothing is pushed, so any out_valid pulse trips the monitor.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", 64'({carry_out, overflow}), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;
    edges = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) edges++;
    end
    check("abort_no_out_valid", 64'(edges), 64'd0);
    do_op(32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0);

    // Back-pressure in DONE with noisy inputs.
    held = '{r: 32'hFFFF_FFFE, co: 1'b1, ov: 1'b0, z: 1'b0};
    out_ready = 1'b0;
    sb_q.push_back(held);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(edges);
    check("hold_latency", 64'(edges), 64'(W / 4 + 1));
    for (int i = 0; i < 5; i++) begin
      in_valid  = ~in_valid;
      operand_a = $urandom;
      operand_b = $urandom;
      sub       = 1'($urandom_range(0, 1));
      tick();
      check("hold_result", 64'(result), 64'(held.r));
      check("hold_flags", 64'({carry_out, overflow}), 64'({held.co, held.ov}));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);

    tick();
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no end, expected end");
    $fatal(1, "timeout");
  end

endmodule
